e203_lsu_disp: RTL and testbench

Parametrised LSU dispatch and response-ordering engine for the E203 core. Takes AGU ICB commands, decodes each address against NPORT programmable regions, forwards the command to the selected target, and records it in an outstanding-transaction FIFO of depth OUTS. Responses are accepted strictly in issue order. Each response is aligned, sign/zero-extended, and steered either back to the AGU or to the write-back port. Sits between the EXU AGU and the ITCM/DTCM/BIU (or further) ICB targets, replacing a fixed three-target controller.

---
 rtl/e203_lsu_disp.sv | 176 +++++++++++++++++
 tb/tb_e203_lsu_disp.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_lsu_disp.sv
// LSU dispatch: decodes AGU commands onto NPORT ICB targets and returns their
// responses strictly in issue order through a small outstanding-command FIFO.
module e203_lsu_disp #(
  parameter int NPORT  = 3,
  parameter int OUTS   = 2,
  parameter int ADDR_W = 32,
  parameter int ITAG_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT*ADDR_W-1:0] region_base,
  input  logic [NPORT*ADDR_W-1:0] region_mask,
  input  logic                    agu_cmd_valid,
  output logic                    agu_cmd_ready,
  input  logic [ADDR_W-1:0]       agu_cmd_addr,
  input  logic                    agu_cmd_read,
  input  logic [31:0]             agu_cmd_wdata,
  input  logic [3:0]              agu_cmd_wmask,
  input  logic [1:0]              agu_cmd_size,
  input  logic                    agu_cmd_usign,
  input  logic                    agu_cmd_back2agu,
  input  logic [ITAG_W-1:0]       agu_cmd_itag,
  output logic                    agu_rsp_valid,
  input  logic                    agu_rsp_ready,
  output logic                    agu_rsp_err,
  output logic [31:0]             agu_rsp_rdata,
  output logic [NPORT-1:0]        tgt_cmd_valid,
  input  logic [NPORT-1:0]        tgt_cmd_ready,
  output logic [ADDR_W-1:0]       tgt_cmd_addr,
  output logic                    tgt_cmd_read,
  output logic [31:0]             tgt_cmd_wdata,
  output logic [3:0]              tgt_cmd_wmask,
  output logic [1:0]              tgt_cmd_size,
  input  logic [NPORT-1:0]        tgt_rsp_valid,
  output logic [NPORT-1:0]        tgt_rsp_ready,
  input  logic [NPORT-1:0]        tgt_rsp_err,
  input  logic [NPORT*32-1:0]     tgt_rsp_rdata,
  output logic                    lsu_o_valid,
  input  logic                    lsu_o_ready,
  output logic [31:0]             lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0]       lsu_o_wbck_itag,
  output logic                    lsu_o_wbck_err,
  output logic                    lsu_o_cmt_ld,
  output logic                    lsu_o_cmt_st,
  output logic                    lsu_o_cmt_buserr,
  output logic [ADDR_W-1:0]       lsu_o_cmt_badaddr,
  output logic                    lsu_active
);
  localparam int SEL_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int PTR_W = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CNT_W = $clog2(OUTS + 1);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              read;
    logic [1:0]        size;
    logic              usign;
    logic              back2agu;
    logic [ITAG_W-1:0] itag;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            fifo_q [OUTS];
  entry_t            head;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full, empty, push, pop;
  logic [SEL_W-1:0]  sel;
  logic [NPORT-2:0]  hit;
  logic              down_ready, rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata, fmt_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              unused_region;

  // The last port is the catch-all, so its region fields carry no meaning.
  assign unused_region = ^{region_base[NPORT*ADDR_W-1 -: ADDR_W],
                           region_mask[NPORT*ADDR_W-1 -: ADDR_W]};

  for (genvar gi = 0; gi < NPORT - 1; gi++) begin : g_dec
    assign hit[gi] = (agu_cmd_addr & region_mask[gi*ADDR_W +: ADDR_W])
                     == region_base[gi*ADDR_W +: ADDR_W];
  end

  // Descending scan so the lowest matching region wins.
  always_comb begin
    sel = SEL_W'(NPORT - 1);
    for (int i = NPORT - 2; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
  end

  assign full  = (cnt_q == CNT_W'(OUTS));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  assign agu_cmd_ready = ~full & tgt_cmd_ready[sel];
  assign push          = agu_cmd_valid & agu_cmd_ready;
  assign tgt_cmd_addr  = agu_cmd_addr;
  assign tgt_cmd_read  = agu_cmd_read;
  assign tgt_cmd_wdata = agu_cmd_wdata;
  assign tgt_cmd_wmask = agu_cmd_wmask;
  assign tgt_cmd_size  = agu_cmd_size;

  assign down_ready = head.back2agu ? agu_rsp_ready : lsu_o_ready;
  assign rsp_valid  = ~empty & tgt_rsp_valid[head.sel];
  assign rsp_err    = ~empty & tgt_rsp_err[head.sel];
  assign rsp_rdata  = tgt_rsp_rdata[32*head.sel +: 32];
  assign pop        = rsp_valid & down_ready;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign tgt_cmd_valid[gi] = agu_cmd_valid & ~full & (sel == SEL_W'(gi));
    // Only the head's target may hand over a response; others are held off.
    assign tgt_rsp_ready[gi] = ~empty & down_ready & (head.sel == SEL_W'(gi));
  end

  assign byte_v = 8'(rsp_rdata >> {head.addr[1:0], 3'b000});
  assign half_v = head.addr[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

  always_comb begin
    case (head.size)
      2'd0:    fmt_data = {{24{~head.usign & byte_v[7]}}, byte_v};
      2'd1:    fmt_data = {{16{~head.usign & half_v[15]}}, half_v};
      default: fmt_data = rsp_rdata;
    endcase
  end

  assign agu_rsp_valid     = rsp_valid & head.back2agu;
  assign agu_rsp_err       = rsp_err;
  assign agu_rsp_rdata     = rsp_rdata;
  assign lsu_o_valid       = rsp_valid & ~head.back2agu;
  assign lsu_o_wbck_wdat   = (rsp_err | ~head.read) ? 32'd0 : fmt_data;
  assign lsu_o_wbck_itag   = head.itag;
  assign lsu_o_wbck_err    = rsp_err;
  assign lsu_o_cmt_buserr  = rsp_err;
  assign lsu_o_cmt_ld      = rsp_err & head.read;
  assign lsu_o_cmt_st      = rsp_err & ~head.read;
  assign lsu_o_cmt_badaddr = rsp_err ? head.addr : '0;
  assign lsu_active        = agu_cmd_valid | ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == PTR_W'(OUTS - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTR_W'(OUTS - 1)) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wptr_q] <= '{sel: sel, read: agu_cmd_read, size: agu_cmd_size,
                          usign: agu_cmd_usign, back2agu: agu_cmd_back2agu,
                          itag: agu_cmd_itag, addr: agu_cmd_addr};
    end
  end

endmodule

// File: tb/tb_e203_lsu_disp.sv
// Directed plus randomized bench for e203_lsu_disp against an in-order
// queue model of outstanding transactions.
module tb_e203_lsu_disp;
  localparam int NPORT = 3;
  localparam int OUTS  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NPORT*32-1:0] region_base, region_mask;
  logic agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign, agu_cmd_back2agu;
  logic [31:0] agu_cmd_addr, agu_cmd_wdata;
  logic [3:0] agu_cmd_wmask;
  logic [1:0] agu_cmd_size;
  logic [0:0] agu_cmd_itag;
  logic agu_rsp_valid, agu_rsp_ready, agu_rsp_err;
  logic [31:0] agu_rsp_rdata;
  logic [NPORT-1:0] tgt_cmd_valid, tgt_cmd_ready, tgt_rsp_valid, tgt_rsp_ready, tgt_rsp_err;
  logic [31:0] tgt_cmd_addr, tgt_cmd_wdata;
  logic tgt_cmd_read;
  logic [3:0] tgt_cmd_wmask;
  logic [1:0] tgt_cmd_size;
  logic [NPORT*32-1:0] tgt_rsp_rdata;
  logic lsu_o_valid, lsu_o_ready, lsu_o_wbck_err;
  logic [31:0] lsu_o_wbck_wdat, lsu_o_cmt_badaddr;
  logic [0:0] lsu_o_wbck_itag;
  logic lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_buserr, lsu_active;

  always #5 clk = ~clk;

  e203_lsu_disp #(.NPORT(NPORT), .OUTS(OUTS), .ADDR_W(32), .ITAG_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .region_base(region_base), .region_mask(region_mask),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_addr(agu_cmd_addr),
    .agu_cmd_read(agu_cmd_read), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_size(agu_cmd_size), .agu_cmd_usign(agu_cmd_usign),
    .agu_cmd_back2agu(agu_cmd_back2agu), .agu_cmd_itag(agu_cmd_itag),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready), .agu_rsp_err(agu_rsp_err),
    .agu_rsp_rdata(agu_rsp_rdata), .tgt_cmd_valid(tgt_cmd_valid), .tgt_cmd_ready(tgt_cmd_ready),
    .tgt_cmd_addr(tgt_cmd_addr), .tgt_cmd_read(tgt_cmd_read), .tgt_cmd_wdata(tgt_cmd_wdata),
    .tgt_cmd_wmask(tgt_cmd_wmask), .tgt_cmd_size(tgt_cmd_size), .tgt_rsp_valid(tgt_rsp_valid),
    .tgt_rsp_ready(tgt_rsp_ready), .tgt_rsp_err(tgt_rsp_err), .tgt_rsp_rdata(tgt_rsp_rdata),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_wdat(lsu_o_wbck_wdat),
    .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_wbck_err(lsu_o_wbck_err),
    .lsu_o_cmt_ld(lsu_o_cmt_ld), .lsu_o_cmt_st(lsu_o_cmt_st),
    .lsu_o_cmt_buserr(lsu_o_cmt_buserr), .lsu_o_cmt_badaddr(lsu_o_cmt_badaddr),
    .lsu_active(lsu_active)
  );

  typedef struct {
    int         port;
    bit         read;
    bit [1:0]   size;
    bit         usign;
    bit         b2a;
    bit         itag;
    logic [31:0] addr;
  } txn_t;

  txn_t exp_q[$];
  logic [31:0] rb [NPORT];
  logic [31:0] rm [NPORT];
  int checks = 0;
  int errors = 0;
  logic [2:0] trdy;
  bit lrdy, ardy;
  logic [2:0] obs_cmd_valid, obs_rsp_ready;
  logic obs_cmd_ready, obs_lsu_v, obs_agu_v, obs_err, obs_st, obs_buserr;
  logic [31:0] obs_wdat, obs_badaddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NPORT - 1; i++)
      if ((a & rm[i]) == rb[i]) return i;
    return NPORT - 1;
  endfunction

  function automatic logic [31:0] ref_fmt(input logic [31:0] d, input logic [1:0] sz,
                                          input bit us, input logic [1:0] off);
    longint unsigned v;
    if (sz == 2'd0) begin
      v = (longint'(d) >> (8 * off)) % 256;
      if (!us && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (longint'(d) >> (16 * off[1])) % 65536;
      if (!us && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(d);
    end
    return v[31:0];
  endfunction

  // One clock of stimulus: drive both sides, check against the model, advance.
  task automatic step(input bit cv, input logic [31:0] a, input bit rd, input logic [1:0] sz,
                      input bit us, input bit b2a, input bit tg,
                      input bit rv, input int rp, input logic [31:0] rdat, input bit rerr);
    int p;
    bit full, exp_rdy, push, pop, hv, down;
    txn_t h;
    logic [2:0] exp_cv, exp_rr;
    logic [31:0] wd, exp_wdat;
    wd = $urandom;
    agu_cmd_valid = cv; agu_cmd_addr = a; agu_cmd_read = rd; agu_cmd_size = sz;
    agu_cmd_usign = us; agu_cmd_back2agu = b2a; agu_cmd_itag = tg;
    agu_cmd_wdata = wd; agu_cmd_wmask = 4'hF;
    tgt_cmd_ready = trdy; lsu_o_ready = lrdy; agu_rsp_ready = ardy;
    tgt_rsp_valid = rv ? 3'(1 << rp) : 3'b000;
    tgt_rsp_err   = (rv && rerr) ? 3'(1 << rp) : 3'b000;
    tgt_rsp_rdata = {rdat, rdat, rdat};
    #1;
    p = ref_decode(a);
    full = (exp_q.size() >= OUTS);
    exp_rdy = !full && trdy[p];
    push = cv && exp_rdy;
    exp_cv = (cv && !full) ? 3'(1 << p) : 3'b000;
    chk("cmd_valid", tgt_cmd_valid, exp_cv);
    chk("cmd_ready", agu_cmd_ready, exp_rdy);
    chk("cmd_addr", tgt_cmd_addr, a);
    chk("cmd_wdata", tgt_cmd_wdata, wd);
    chk("cmd_read", tgt_cmd_read, rd);
    chk("cmd_size", tgt_cmd_size, sz);
    chk("active", lsu_active, cv || exp_q.size() > 0);
    h = '{default: 0};
    pop = 0; hv = 0; exp_rr = 3'b000;
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      down = h.b2a ? ardy : lrdy;
      exp_rr = down ? 3'(1 << h.port) : 3'b000;
      hv = rv && (rp == h.port);
      pop = hv && down;
    end
    chk("rsp_ready", tgt_rsp_ready, exp_rr);
    chk("lsu_valid", lsu_o_valid, hv && !h.b2a);
    chk("agu_valid", agu_rsp_valid, hv && h.b2a);
    if (hv && !h.b2a) begin
      exp_wdat = (rerr || !h.read) ? 32'd0 : ref_fmt(rdat, h.size, h.usign, h.addr[1:0]);
      chk("wbck_wdat", lsu_o_wbck_wdat, exp_wdat);
      chk("wbck_itag", lsu_o_wbck_itag, h.itag);
      chk("wbck_err", lsu_o_wbck_err, rerr);
      chk("cmt_buserr", lsu_o_cmt_buserr, rerr);
      chk("cmt_ld", lsu_o_cmt_ld, rerr && h.read);
      chk("cmt_st", lsu_o_cmt_st, rerr && !h.read);
      chk("cmt_badaddr", lsu_o_cmt_badaddr, rerr ? h.addr : 32'd0);
    end
    if (hv && h.b2a) begin
      chk("agu_rdata", agu_rsp_rdata, rdat);
      chk("agu_err", agu_rsp_err, rerr);
    end
    obs_cmd_valid = tgt_cmd_valid; obs_cmd_ready = agu_cmd_ready; obs_rsp_ready = tgt_rsp_ready;
    obs_lsu_v = lsu_o_valid; obs_agu_v = agu_rsp_valid; obs_wdat = lsu_o_wbck_wdat;
    obs_err = lsu_o_wbck_err; obs_st = lsu_o_cmt_st; obs_buserr = lsu_o_cmt_buserr;
    obs_badaddr = lsu_o_cmt_badaddr;
    $display("step cmd=%0b addr=%h rsp=%0b port=%0d pend=%0d push=%0b pop=%0b",
             cv, a, rv, rp, exp_q.size(), push, pop);
    @(posedge clk); #1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back('{p, rd, sz, us, b2a, tg, a});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    // Region1 overlaps region0 on purpose so the lowest index must win.
    rb[0] = 32'h8000_0000; rm[0] = 32'hFFFF_0000;
    rb[1] = 32'h8000_0000; rm[1] = 32'hF000_0000;
    rb[2] = 32'h0000_0000; rm[2] = 32'h0000_0000;
    region_base = {rb[2], rb[1], rb[0]};
    region_mask = {rm[2], rm[1], rm[0]};
    trdy = 3'b111; lrdy = 1; ardy = 1;
    rst_n = 0;
    agu_cmd_valid = 0; agu_cmd_addr = 0; agu_cmd_read = 1; agu_cmd_size = 2'd2;
    agu_cmd_usign = 0; agu_cmd_back2agu = 0; agu_cmd_itag = 0; agu_cmd_wdata = 0;
    agu_cmd_wmask = 4'hF; tgt_cmd_ready = trdy; tgt_rsp_valid = 0; tgt_rsp_err = 0;
    tgt_rsp_rdata = '0; lsu_o_ready = 1; agu_rsp_ready = 1;
    #2;
    chk("rst_cmd_ready", agu_cmd_ready, 1);
    chk("rst_active", lsu_active, 0);
    chk("rst_cmd_valid", tgt_cmd_valid, 0);
    chk("rst_rsp_ready", tgt_rsp_ready, 0);
    chk("rst_lsu_valid", lsu_o_valid, 0);
    chk("rst_agu_valid", agu_rsp_valid, 0);
    tgt_cmd_ready = 3'b011;
    #1;
    chk("rst_cmd_ready_follow", agu_cmd_ready, 0);
    agu_cmd_valid = 1; tgt_cmd_ready = trdy;
    #1;
    chk("rst_active_follow", lsu_active, 1);
    agu_cmd_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // Word load to port0.
    step(1, 32'h8000_0010, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0, 0);
    chk("tp_word_sel", obs_cmd_valid, 3'b001);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'h1234_5678, 0);
    chk("tp_word_wdat", obs_wdat, 32'h1234_5678);
    chk("tp_word_buserr", obs_buserr, 0);
    // Overlapping region resolves to port1 outside region0.
    step(1, 32'h8100_0000, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("tp_prio_sel", obs_cmd_valid, 3'b010);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 1, 32'hA5A5_5A5A, 0);

    // Signed / unsigned byte at offset 3.
    step(1, 32'h8000_0003, 1, 2'd0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'h80FF_0000, 0);
    chk("tp_byte_signed", obs_wdat, 32'hFFFF_FF80);
    step(1, 32'h8000_0003, 1, 2'd0, 1, 0, 0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'h80FF_0000, 0);
    chk("tp_byte_unsigned", obs_wdat, 32'h0000_0080);

    // Out-of-order target responses: A to port2, B to port0.
    step(1, 32'h2000_0000, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 32'h8000_0020, 1, 2'd1, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'hBEEF_0001, 0);
    chk("tp_ooo_hold", obs_rsp_ready[0], 0);
    chk("tp_ooo_nowb", obs_lsu_v, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 2, 32'h1111_2222, 0);
    chk("tp_ooo_a", obs_wdat, 32'h1111_2222);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'h8001_7FFF, 0);
    chk("tp_ooo_b", obs_wdat, 32'h0000_7FFF);

    // Fill, hold off, then overlap push and pop across pointer wrap.
    step(1, 32'h8000_0100, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 32'h8100_0000, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0, 0);
    step(1, 32'h2000_0008, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("tp_full_ready", obs_cmd_ready, 0);
    step(1, 32'h2000_0008, 1, 2'd2, 0, 0, 0, 1, 0, 32'h0000_0001, 0);
    chk("tp_full_pop_noreuse", obs_cmd_ready, 0);
    step(1, 32'h2000_0008, 1, 2'd2, 0, 0, 0, 1, 1, 32'h0000_0002, 0);
    chk("tp_pushpop_ready", obs_cmd_ready, 1);
    step(1, 32'h8000_0200, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0, 0);
    step(1, 32'h8000_0300, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("tp_refull_ready", obs_cmd_ready, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 2, 32'h0000_0003, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'h0000_0004, 0);
    chk("tp_wrap_data", obs_wdat, 32'h0000_0004);

    // Store with bus error on port2.
    step(1, 32'h2000_0004, 0, 2'd2, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 2, 32'hFFFF_FFFF, 1);
    chk("tp_st_err", obs_err, 1);
    chk("tp_st_buserr", obs_buserr, 1);
    chk("tp_st_cmt_st", obs_st, 1);
    chk("tp_st_badaddr", obs_badaddr, 32'h2000_0004);
    chk("tp_st_wdat", obs_wdat, 0);

    // Response routed back to the AGU.
    step(1, 32'h8000_0040, 1, 2'd0, 0, 1, 0, 0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, 0, 32'hCAFE_F00D, 0);
    chk("tp_b2a_agu", obs_agu_v, 1);
    chk("tp_b2a_lsu", obs_lsu_v, 0);

    // Reset while a command is outstanding.
    step(1, 32'h8000_0050, 1, 2'd2, 0, 0, 0, 0, 0, 32'h0, 0);
    rst_n = 0; agu_cmd_valid = 0; tgt_rsp_valid = 3'b001;
    #1;
    chk("tp_rst_active", lsu_active, 0);
    chk("tp_rst_rsp_ready", tgt_rsp_ready, 0);
    chk("tp_rst_lsu_valid", lsu_o_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1; tgt_rsp_valid = 0;
    idle(2);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      int k, rp;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = (k == 0) ? {16'h8000, 16'($urandom)} :
          (k == 1) ? {4'h8, 28'($urandom)} : 32'($urandom);
      trdy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      lrdy = ($urandom_range(0, 4) != 0);
      ardy = ($urandom_range(0, 4) != 0);
      rp = (exp_q.size() > 0 && $urandom_range(0, 3) != 0) ? exp_q[0].port
                                                         : $urandom_range(0, 2);
      step($urandom_range(0, 1), a, $urandom_range(0, 1), 2'($urandom_range(0, 2)),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), rp, $urandom, ($urandom_range(0, 7) == 0));
    end

    trdy = 3'b111; lrdy = 1; ardy = 1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++)
      step(0, 32'h0, 1, 2'd2, 0, 0, 0, 1, exp_q[0].port, $urandom, 0);
    chk("drain_empty", exp_q.size(), 0);
    #1;
    chk("final_active", lsu_active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
